// File: rtl/issue_queue_ctrl_pkg.sv
// Shared types for the in-order issue stage: decoded-op encoding, pipeline
// payload structs, op-class helper functions and the delay-slot FSM states.
package issue_queue_ctrl_pkg;

  // Widest issue group the control logic is written to support.
  localparam int ISSUE_WIDTH_MAX = 4;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_OR, OP_MUL,
    OP_LW, OP_LB, OP_SW, OP_SB,
    OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR,
    OP_MOVZ, OP_MOVN,
    OP_ERET, OP_MTC0, OP_MFC0, OP_SYSCALL
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [4:0] reg_addr1;
    logic [4:0] reg_addr2;
    logic       delayslot;
  } PipelineData_t;

  typedef struct packed {
    logic       we;
    logic [4:0] waddr;
  } RegWrite_t;

  typedef struct packed {
    RegWrite_t reg_wr;
  } PipelineReq_t;

  // Summary of the group selected this cycle.
  typedef struct packed {
    logic [2:0] n_issue;
    logic       last_jump;
  } IssueGroup_t;

  typedef enum logic {
    ST_NORMAL,
    ST_DS_PENDING
  } ds_state_t;

  function automatic logic is_jump_inst(op_t op);
    return op inside {OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR};
  endfunction

  function automatic logic is_read_memory_inst(op_t op);
    return op inside {OP_LW, OP_LB};
  endfunction

  function automatic logic is_write_memory_inst(op_t op);
    return op inside {OP_SW, OP_SB};
  endfunction

  function automatic logic is_privileged_inst(op_t op);
    return op inside {OP_ERET, OP_MTC0, OP_MFC0, OP_SYSCALL};
  endfunction

  function automatic logic is_cond_move_inst(op_t op);
    return op inside {OP_MOVZ, OP_MOVN};
  endfunction

endpackage

// File: rtl/issue_pair_hazard.sv
// Combinational hazard check between an older and a younger queue entry that
// would share one issue group.
module issue_pair_hazard
  import issue_queue_ctrl_pkg::*;
(
  input  op_t        older_op,
  input  logic       older_we,
  input  logic [4:0] older_waddr,
  input  op_t        younger_op,
  input  logic [4:0] younger_ra1,
  input  logic [4:0] younger_ra2,
  output logic       raw_load,
  output logic       raw_mul,
  output logic       raw_cmov,
  output logic       mem_conflict
);

  logic w_reads_dst;
  logic w_dst_nonzero;

  assign w_reads_dst   = older_we && ((younger_ra1 == older_waddr) || (younger_ra2 == older_waddr));
  assign w_dst_nonzero = (older_waddr != 5'd0);

  // Load and MUL results are not forwardable within the same group.
  assign raw_load = w_reads_dst && w_dst_nonzero && is_read_memory_inst(older_op);
  assign raw_mul  = w_reads_dst && w_dst_nonzero && (older_op == OP_MUL);

  // Conditional moves need the final value of every source, from any producer.
  assign raw_cmov = w_reads_dst && is_cond_move_inst(younger_op);

  // Only one memory port: at most one load/store per group.
  assign mem_conflict = (is_read_memory_inst(older_op) || is_write_memory_inst(older_op)) &&
                        (is_read_memory_inst(younger_op) || is_write_memory_inst(younger_op));

endmodule

// File: rtl/issue_queue_ctrl.sv
// In-order issue stage: circular queue between decode and EX that presents,
// every cycle, the longest legal in-order group of up to ISSUE_WIDTH entries
// from the head, and tracks branch delay slots across cycles.
// Optional feature macro: ISSUE_DS_PAIR_EN (slot-0 jump may pair with its
// delay slot in slot 1).
//
// Handshake: enqueue fires when |enq_valid && enq_ready (enq_ready is a
// function of registered state only); the issue group fires when
// issue_valid[0] && issue_ready, and the whole presented group is consumed.
module issue_queue_ctrl
  import issue_queue_ctrl_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2   // 1..ISSUE_WIDTH_MAX
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic          [FETCH_WIDTH-1:0]    enq_valid,
  input  PipelineData_t [FETCH_WIDTH-1:0]    enq_data,
  input  PipelineReq_t  [FETCH_WIDTH-1:0]    enq_req,
  output logic                               enq_ready,
  output logic          [ISSUE_WIDTH-1:0]    issue_valid,
  output PipelineData_t [ISSUE_WIDTH-1:0]    issue_data,
  output PipelineReq_t  [ISSUE_WIDTH-1:0]    issue_req,
  input  logic                               issue_ready,
  output ds_state_t                          o_dbg_state,
  output logic          [$clog2(DEPTH):0]    o_dbg_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NPAIR = ISSUE_WIDTH * ISSUE_WIDTH;

  PipelineData_t    r_data_q [DEPTH];
  PipelineReq_t     r_req_q  [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  ds_state_t        r_state;

  PipelineData_t    w_slot_data   [ISSUE_WIDTH];
  PipelineReq_t     w_slot_req    [ISSUE_WIDTH];
  logic             w_slot_exists [ISSUE_WIDTH];
  logic [NPAIR-1:0] w_raw_load;
  logic [NPAIR-1:0] w_raw_mul;
  logic [NPAIR-1:0] w_raw_cmov;
  logic [NPAIR-1:0] w_mem_conflict;
  logic             w_end;
  logic             w_prev_valid;
  logic             w_prev_jump;
  logic             w_older_block;
  IssueGroup_t      w_group;
  logic [CNT_W-1:0] w_n_enq;
  logic [CNT_W-1:0] w_n_enq_eff;
  logic [CNT_W-1:0] w_n_deq;
  logic             w_enq_fire;
  logic             w_deq_fire;

  // Look up the ISSUE_WIDTH oldest entries and whether each one exists.
  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      w_slot_data[k]   = r_data_q[r_head + PTR_W'(k)];
      w_slot_req[k]    = r_req_q[r_head + PTR_W'(k)];
      w_slot_exists[k] = (CNT_W'(k) < r_count);
      issue_data[k]    = w_slot_data[k];
      issue_req[k]     = w_slot_req[k];
    end
  end

  // One hazard checker per ordered (older, younger) slot pair.
  for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_old
    for (genvar gk = 0; gk < ISSUE_WIDTH; gk++) begin : g_young
      if (gk > gi) begin : g_pair
        issue_pair_hazard u_hazard (
          .older_op     (w_slot_data[gi].op),
          .older_we     (w_slot_req[gi].reg_wr.we),
          .older_waddr  (w_slot_req[gi].reg_wr.waddr),
          .younger_op   (w_slot_data[gk].op),
          .younger_ra1  (w_slot_data[gk].reg_addr1),
          .younger_ra2  (w_slot_data[gk].reg_addr2),
          .raw_load     (w_raw_load[gi*ISSUE_WIDTH+gk]),
          .raw_mul      (w_raw_mul[gi*ISSUE_WIDTH+gk]),
          .raw_cmov     (w_raw_cmov[gi*ISSUE_WIDTH+gk]),
          .mem_conflict (w_mem_conflict[gi*ISSUE_WIDTH+gk])
        );
      end else begin : g_none
        assign w_raw_load[gi*ISSUE_WIDTH+gk]     = 1'b0;
        assign w_raw_mul[gi*ISSUE_WIDTH+gk]      = 1'b0;
        assign w_raw_cmov[gi*ISSUE_WIDTH+gk]     = 1'b0;
        assign w_mem_conflict[gi*ISSUE_WIDTH+gk] = 1'b0;
      end
    end
  end

  // Grow the group from slot 0 until the first slot that ends it.
  always_comb begin
    issue_valid   = '0;
    w_group       = '0;
    w_end         = 1'b0;
    w_older_block = 1'b0;
    w_prev_valid  = 1'b1;
    w_prev_jump   = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      w_end = 1'b0;
      if (k > 0) begin
        w_end = is_jump_inst(w_slot_data[k].op) ||
                is_privileged_inst(w_slot_data[k].op) ||
                (r_state == ST_DS_PENDING);
`ifdef ISSUE_DS_PAIR_EN
        // A slot-0 jump may take its delay slot along, but nothing beyond it.
        if (k >= 2)
          w_end = w_end || w_prev_jump || is_jump_inst(w_slot_data[0].op);
`else
        w_end = w_end || w_prev_jump;
`endif
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
          w_older_block = (i < k) &&
                          (is_privileged_inst(w_slot_data[i].op) ||
                           w_raw_load[i*ISSUE_WIDTH+k] || w_raw_mul[i*ISSUE_WIDTH+k] ||
                           w_raw_cmov[i*ISSUE_WIDTH+k] || w_mem_conflict[i*ISSUE_WIDTH+k]);
          w_end = w_end || w_older_block;
        end
      end
      issue_valid[k] = w_slot_exists[k] && w_prev_valid && !w_end;
      if (issue_valid[k]) begin
        w_group.n_issue   = w_group.n_issue + 3'd1;
        w_group.last_jump = is_jump_inst(w_slot_data[k].op);
      end
      w_prev_valid = issue_valid[k];
      w_prev_jump  = is_jump_inst(w_slot_data[k].op);
    end
  end

  // Enqueue lane count and the fire conditions on both sides.
  always_comb begin
    w_n_enq = '0;
    for (int j = 0; j < FETCH_WIDTH; j++)
      if (enq_valid[j]) w_n_enq = w_n_enq + CNT_W'(1);
  end

  assign enq_ready   = (r_count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign w_enq_fire  = (|enq_valid) && enq_ready && !flush && !rst;
  assign w_n_enq_eff = w_enq_fire ? w_n_enq : '0;
  assign w_deq_fire  = issue_valid[0] && issue_ready;
  assign w_n_deq     = w_deq_fire ? CNT_W'(w_group.n_issue) : '0;

  assign o_dbg_state = r_state;
  assign o_dbg_count = r_count;

  // Queue payload storage; no reset, validity is carried by the count.
  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (w_enq_fire && enq_valid[j]) begin
        r_data_q[r_tail + PTR_W'(j)] <= enq_data[j];
        r_req_q[r_tail + PTR_W'(j)]  <= enq_req[j];
      end
    end
  end

  // Head/tail pointers and occupancy; flush drops everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_n_deq);
      r_tail  <= r_tail + PTR_W'(w_n_enq_eff);
      r_count <= r_count + w_n_enq_eff - w_n_deq;
    end
  end

  // Delay-slot FSM: a group ending in a jump leaves its delay slot to issue alone.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= ST_NORMAL;
    end else if (w_deq_fire) begin
      case (r_state)
        ST_NORMAL:     if (w_group.last_jump) r_state <= ST_DS_PENDING;
        ST_DS_PENDING: r_state <= ST_NORMAL;
        default:       r_state <= ST_NORMAL;
      endcase
    end
  end

endmodule
